// File: rtl/fifo_read_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: the FSM state
// encoding (also exposed on the debug state port) and the depth of the
// internal output buffer.
package fifo_read_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Two entries let the adapter read one word ahead of a stalled consumer,
    // so rinc never has to look at m_ready combinationally.
    localparam int         BUF_DEPTH  = 2;
    localparam logic [1:0] LEVEL_FULL = 2'(BUF_DEPTH);

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the stream
// output. Entry 0 is always the oldest word and drives head; entry 1 only
// holds data when level is 2. Push and pop in the same cycle keep the level.
module rd_skid_buf
    import fifo_read_stream_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [DSIZE-1:0] din,
    output logic [1:0]       level,
    output logic [DSIZE-1:0] head
);

    logic [DSIZE-1:0] entry0;
    logic [DSIZE-1:0] entry1;
    logic             do_push;
    logic             do_pop;

    // Requests that would overflow or underflow are dropped so level stays 0..2.
    assign do_push = push && (level != LEVEL_FULL);
    assign do_pop  = pop && (level != 2'd0);
    assign head    = entry0;

    // Storage and occupancy: shift entry 1 forward on a pop, fill the first free slot on a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            level  <= 2'd0;
        end else if (clear) begin
            level <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (level == 2'd0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    level <= level + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    level  <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_stream.sv
// Converts an async FIFO read port (rdata/rempty/rinc) into a valid/ready
// stream. Words are read one cycle ahead into a two-entry buffer so that a
// full-rate consumer gets one word per cycle, while rinc is computed only
// from local state and rempty. A flush request drains the FIFO and discards
// everything until the FIFO reports empty.
//
// Handshake: m_valid/m_data come from registers only; a transfer happens on
// every rclk edge where m_valid=1 and m_ready=1, and while m_valid=1 and
// m_ready=0 neither m_valid nor m_data changes. rinc pops the FIFO on every
// edge where it is high (it is only raised while rempty=0).
module fifo_read_stream
    import fifo_read_stream_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic             flush_busy,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] rd_count,
    output logic [1:0]       state
);

    state_t           state_q;
    logic             flush_take;
    logic             push;
    logic             pop;
    logic [1:0]       level_next;
    logic [DSIZE-1:0] head;

    rd_skid_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .clk   (rclk),
        .rst   (rrst),
        .push  (push),
        .pop   (pop),
        .clear (flush_take),
        .din   (rdata),
        .level (level),
        .head  (head)
    );

    assign state   = state_q;
    assign m_data  = head;
    assign m_valid = (level != 2'd0) && (state_q != FLUSH);

    // A flush is only accepted outside FLUSH; on the accepting edge it wins
    // over the stream, so the word on m_data is dropped rather than counted.
    assign flush_take = flush && (state_q != FLUSH);
    assign push       = rinc && (state_q == STREAM) && !flush;
    assign pop        = m_valid && m_ready && !flush;
    assign level_next = level + 2'(push) - 2'(pop);

    // FIFO read-advance: read ahead while there is buffer room, drain blindly while flushing.
    always_comb begin
        rinc = 1'b0;
        case (state_q)
            STREAM:  rinc = !rempty && (level < LEVEL_FULL);
            FLUSH:   rinc = !rempty;
            default: rinc = 1'b0;
        endcase
    end

    // Control FSM with registered flush_busy.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q    <= IDLE;
            flush_busy <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q    <= FLUSH;
                        flush_busy <= 1'b1;
                    end else if (!rempty) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (flush) begin
                        state_q    <= FLUSH;
                        flush_busy <= 1'b1;
                    end else if ((level_next == 2'd0) && rempty) begin
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (rempty) begin
                        state_q    <= IDLE;
                        flush_busy <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    flush_busy <= 1'b0;
                end
            endcase
        end
    end

    // Delivered-word counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fifo_read_stream.md
FIFO_READ_STREAM -- requirements
Module: fifo_read_stream

Interface
REQ-001 Parameter DSIZE, default 8: data word width; matches the async FIFO read port.
REQ-002 Parameter CNT_W, default 16: width of the delivered-word counter.
REQ-003 rclk  input  1: single clock (FIFO read domain); all state on rising edge.
REQ-004 rrst  input  1: asynchronous, active-high reset.
REQ-005 rdata  input  DSIZE: FIFO read data; combinational from the current read address; valid while rempty=0.
REQ-006 rempty  input  1: registered FIFO empty flag.
REQ-007 rinc  output  1: FIFO read-advance; pops one word at the rclk edge when rempty=0.
REQ-008 m_data  output  DSIZE: stream data to the consumer.
REQ-009 m_valid  output  1: m_data valid.
REQ-010 m_ready  input  1: consumer accepts; a transfer occurs on an edge with m_valid=1 and m_ready=1.
REQ-011 flush  input  1: single-cycle request to discard buffered and FIFO-resident data.
REQ-012 flush_busy  output  1: flush in progress.
REQ-013 level  output  2: words held in the internal buffer (0..2).
REQ-014 rd_count  output  CNT_W: count of words transferred on the stream.

Function
REQ-015 Internal 2-entry buffer: head entry drives m_data; m_valid = (level != 0) and state != FLUSH.
REQ-016 Capture: on an edge with rinc=1, rdata is written into the buffer; it reaches m_data no earlier than the next cycle.
REQ-017 rinc = !rempty and level < 2 in STREAM; rinc SHALL NOT depend combinationally on m_ready.
REQ-018 With m_ready held at 1 and the FIFO non-empty, throughput is 1 word/cycle (level steady at 1).
REQ-019 Simultaneous push and pop: level unchanged; ordering strictly FIFO; no word duplicated or lost.
REQ-020 m_data and m_valid hold stable while m_valid=1 and m_ready=0.
REQ-021 level never exceeds 2; a push at level 2 is impossible by REQ-017.
REQ-022 States: IDLE (level=0, rempty=1), STREAM (data present or arriving), FLUSH.
REQ-023 IDLE->STREAM when rempty=0; STREAM->IDLE when level becomes 0 with rempty=1.
REQ-024 flush=1 in IDLE or STREAM -> FLUSH next cycle; buffer cleared (level=0); pending word not transferred.
REQ-025 In FLUSH: rinc = !rempty; data discarded; m_valid=0; flush_busy=1; rd_count frozen.
REQ-026 FLUSH->IDLE on the first edge sampling rempty=1; flush asserted while in FLUSH is ignored.
REQ-027 rd_count increments by 1 per stream transfer; wraps modulo 2^CNT_W without saturation.

Reset
REQ-028 While rrst=1: state=IDLE, level=0, m_valid=0, rinc=0, flush_busy=0, rd_count=0, m_data=0.
REQ-029 Reset asserted mid-transfer discards buffered words; no rinc pulse during or on the first edge after release.

Structure
REQ-030 A shared package holds the state enumeration (IDLE, STREAM, FLUSH) and the buffer depth constant (2).
REQ-031 The 2-entry buffer is one sub-module, rd_skid_buf (push/pop/clear, level, head data); FSM, rinc and counter live in fifo_read_stream.

Verification
REQ-032 FIFO holds 0x11,0x22,0x33, m_ready=1 -> rinc three consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles; rd_count=3; state returns to IDLE.
REQ-033 5 words available, m_ready=0 for 10 cycles -> rinc pulses exactly twice, level=2, m_data stable at word 0; m_ready=1 -> all 5 delivered in order.
REQ-034 m_ready toggling 1/0 each cycle over 20 words -> 20 transfers, order intact, level never 3, no duplicates.
REQ-035 flush with level=2 and 4 words in the FIFO -> m_valid=0 next cycle; rinc asserted 4 cycles; flush_busy deasserts after rempty=1; rd_count unchanged.
REQ-036 rd_count preset near wrap (CNT_W=4, 15 transfers done) plus 2 more transfers -> rd_count reads 1.
REQ-037 rrst pulsed with level=2 -> all outputs at reset values asynchronously; rinc=0 on the first edge after release.
